// File: rtl/pc_gen_ras.sv
// -----------------------------------------------------------------------------
// pc_gen_ras
//
// Program-counter generator with a circular return-address stack (RAS).
// Decode supplies Mode/Taken/BranchOff/RA. The block produces the registered
// instruction address for instruction memory.
//
// Ports
//   Clock      : rising-edge clock, sole clock
//   Reset      : synchronous, active-high; takes priority over Enable
//   Enable     : 1 = advance this cycle, 0 = stall (all state held)
//   Mode       : next-address mode
//                000 SEQ, 001 BR, 010 JREG, 011 CALL, 100 RET, 101 CALLR,
//                110/111 reserved
//   Taken      : branch condition, used only in BR mode
//   BranchOff  : signed byte offset, two's complement
//   RA         : register-file address for JREG/CALLR and the RET fallback
//   PC         : current instruction address
//   PC_temp    : address of the previously executed instruction
//   RAS_count  : number of valid stack entries, 0..RAS_DEPTH
//   RAS_ovf    : one-cycle pulse after a push onto a full stack
//   RAS_unf    : one-cycle pulse after a RET on an empty stack
//   Illegal    : one-cycle pulse after a reserved Mode was accepted
//
// All outputs are registered. No input reaches an output combinationally.
// -----------------------------------------------------------------------------
module pc_gen_ras #(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       RAS_DEPTH = 8,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter logic [ADDR_W-1:0] INC       = ADDR_W'(4)
) (
    input  logic                         Clock,
    input  logic                         Reset,
    input  logic                         Enable,
    input  logic [2:0]                   Mode,
    input  logic                         Taken,
    input  logic [ADDR_W-1:0]            BranchOff,
    input  logic [ADDR_W-1:0]            RA,
    output logic [ADDR_W-1:0]            PC,
    output logic [ADDR_W-1:0]            PC_temp,
    output logic [$clog2(RAS_DEPTH):0]   RAS_count,
    output logic                         RAS_ovf,
    output logic                         RAS_unf,
    output logic                         Illegal
);

    localparam int unsigned      PTR_W      = $clog2(RAS_DEPTH);
    localparam int unsigned      CNT_W      = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(RAS_DEPTH);

    typedef enum logic [2:0] {
        MODE_SEQ   = 3'b000,
        MODE_BR    = 3'b001,
        MODE_JREG  = 3'b010,
        MODE_CALL  = 3'b011,
        MODE_RET   = 3'b100,
        MODE_CALLR = 3'b101,
        MODE_RSV6  = 3'b110,
        MODE_RSV7  = 3'b111
    } modeT;

    // Stack storage and pointer. The pointer always names the next free slot,
    // so the top of stack sits at rasPtr-1. Because RAS_DEPTH is a power of
    // two, the pointer arithmetic wraps on its own.
    logic [ADDR_W-1:0] rasStack [RAS_DEPTH];
    logic [PTR_W-1:0]  rasPtr;

    logic [ADDR_W-1:0] seqAddr;
    logic [ADDR_W-1:0] relAddr;
    logic [ADDR_W-1:0] topAddr;
    logic [ADDR_W-1:0] nextPc;
    logic              doPush;
    logic              doPop;
    logic              stackEmpty;
    logic              stackFull;
    logic              ovfEvent;
    logic              unfEvent;
    logic              illEvent;

    assign seqAddr    = PC + INC;
    assign relAddr    = PC + BranchOff;
    assign topAddr    = rasStack[rasPtr - PTR_W'(1)];
    assign stackEmpty = (RAS_count == '0);
    assign stackFull  = (RAS_count == FULL_COUNT);

    // Next-address selection and stack control decode
    always_comb begin
        nextPc   = seqAddr;
        doPush   = 1'b0;
        doPop    = 1'b0;
        unfEvent = 1'b0;
        illEvent = 1'b0;
        case (Mode)
            MODE_SEQ: begin
                nextPc = seqAddr;
            end
            MODE_BR: begin
                nextPc = Taken ? relAddr : seqAddr;
            end
            MODE_JREG: begin
                nextPc = RA;
            end
            MODE_CALL: begin
                nextPc = relAddr;
                doPush = 1'b1;
            end
            MODE_RET: begin
                if (!stackEmpty) begin
                    nextPc = topAddr;
                    doPop  = 1'b1;
                end else begin
                    // An empty stack falls back to the register-file address.
                    nextPc   = RA;
                    unfEvent = 1'b1;
                end
            end
            MODE_CALLR: begin
                nextPc = RA;
                doPush = 1'b1;
            end
            default: begin
                nextPc   = seqAddr;
                illEvent = 1'b1;
            end
        endcase
    end

    // A push onto a full stack overwrites the oldest entry. That entry is the
    // slot the pointer already names, so the write path does not change.
    assign ovfEvent = doPush && stackFull;

    // PC, pointer, count and pulse registers
    always_ff @(posedge Clock) begin
        if (Reset) begin
            PC        <= RESET_VEC;
            PC_temp   <= RESET_VEC;
            rasPtr    <= '0;
            RAS_count <= '0;
            RAS_ovf   <= 1'b0;
            RAS_unf   <= 1'b0;
            Illegal   <= 1'b0;
        end else if (!Enable) begin
            RAS_ovf <= 1'b0;
            RAS_unf <= 1'b0;
            Illegal <= 1'b0;
        end else begin
            PC_temp <= PC;
            PC      <= nextPc;
            RAS_ovf <= ovfEvent;
            RAS_unf <= unfEvent;
            Illegal <= illEvent;
            if (doPush) begin
                rasPtr <= rasPtr + PTR_W'(1);
                if (!stackFull) begin
                    RAS_count <= RAS_count + CNT_W'(1);
                end
            end else if (doPop) begin
                rasPtr    <= rasPtr - PTR_W'(1);
                RAS_count <= RAS_count - CNT_W'(1);
            end
        end
    end

    // Stack entries need no reset because their contents are don't-care
    // until they are written.
    always_ff @(posedge Clock) begin
        if (!Reset && Enable && doPush) begin
            rasStack[rasPtr] <= seqAddr;
        end
    end

endmodule

// File: tb/tb_pc_gen_ras.sv
// -----------------------------------------------------------------------------
// tb_pc_gen_ras
//
// Bench for pc_gen_ras with RESET_VEC=0x100 and RAS_DEPTH=8. A reference model
// tracks PC, PC_temp and the return stack as a bounded queue. A negedge compare
// process checks every DUT output against the model. Directed scenarios also
// check hand-computed literal values, and a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_pc_gen_ras;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DEPTH = 8;
  localparam logic [31:0] RV = 32'h100;

  localparam logic [2:0] M_SEQ = 3'b000;
  localparam logic [2:0] M_BR = 3'b001;
  localparam logic [2:0] M_JREG = 3'b010;
  localparam logic [2:0] M_CALL = 3'b011;
  localparam logic [2:0] M_RET = 3'b100;
  localparam logic [2:0] M_CALLR = 3'b101;

  // ---------------- clock / reset ----------------
  logic Clock;
  logic Reset;
  logic Enable;
  logic [2:0] Mode;
  logic Taken;
  logic [31:0] BranchOff;
  logic [31:0] RA;
  logic [31:0] PC;
  logic [31:0] PC_temp;
  logic [3:0] RAS_count;
  logic RAS_ovf;
  logic RAS_unf;
  logic Illegal;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  pc_gen_ras #(
    .ADDR_W(ADDR_W),
    .RAS_DEPTH(DEPTH),
    .RESET_VEC(RV),
    .INC(32'd4)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .Enable(Enable),
    .Mode(Mode),
    .Taken(Taken),
    .BranchOff(BranchOff),
    .RA(RA),
    .PC(PC),
    .PC_temp(PC_temp),
    .RAS_count(RAS_count),
    .RAS_ovf(RAS_ovf),
    .RAS_unf(RAS_unf),
    .Illegal(Illegal)
  );

  // ---------------- reference model ----------------
  logic [31:0] m_pc;
  logic [31:0] m_temp;
  logic [31:0] m_stack[$];
  logic m_ovf;
  logic m_unf;
  logic m_ill;
  bit started = 1'b0;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic rst, input logic en, input logic [2:0] md,
                            input logic tk, input logic [31:0] off, input logic [31:0] ra);
    logic [31:0] nxt;
    logic [31:0] seq;
    seq = m_pc + 32'd4;
    if (rst) begin
      m_pc = RV;
      m_temp = RV;
      m_stack.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_ill = 1'b0;
    end else if (!en) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_ill = 1'b0;
    end else begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_ill = 1'b0;
      nxt = seq;
      case (md)
        3'd0: nxt = seq;
        3'd1: nxt = tk ? m_pc + off : seq;
        3'd2: nxt = ra;
        3'd3, 3'd5: begin
          nxt = (md == 3'd3) ? m_pc + off : ra;
          m_stack.push_back(seq);
          if (m_stack.size() > DEPTH) begin
            void'(m_stack.pop_front());
            m_ovf = 1'b1;
          end
        end
        3'd4: begin
          if (m_stack.size() > 0) begin
            nxt = m_stack.pop_back();
          end else begin
            nxt = ra;
            m_unf = 1'b1;
          end
        end
        default: begin
          nxt = seq;
          m_ill = 1'b1;
        end
      endcase
      m_temp = m_pc;
      m_pc = nxt;
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge Clock) begin
    if (started) begin
      check("pc", PC, m_pc);
      check("pc_temp", PC_temp, m_temp);
      check("ras_count", 32'(RAS_count), 32'(m_stack.size()));
      check("ras_ovf", 32'(RAS_ovf), 32'(m_ovf));
      check("ras_unf", 32'(RAS_unf), 32'(m_unf));
      check("illegal", 32'(Illegal), 32'(m_ill));
    end
  end

  // ---------------- driver ----------------
  task automatic step(input logic rst, input logic en, input logic [2:0] md,
                      input logic tk, input logic [31:0] off, input logic [31:0] ra);
    Reset = rst;
    Enable = en;
    Mode = md;
    Taken = tk;
    BranchOff = off;
    RA = ra;
    @(posedge Clock);
    model_step(rst, en, md, tk, off, ra);
    started = 1'b1;
    @(negedge Clock);
  endtask

  task automatic go(input logic [2:0] md, input logic [31:0] off, input logic [31:0] ra);
    step(1'b0, 1'b1, md, 1'b0, off, ra);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] exp_pc;
    Reset = 1'b1;
    Enable = 1'b0;
    Mode = '0;
    Taken = 1'b0;
    BranchOff = '0;
    RA = '0;

    // Reset state
    step(1'b1, 1'b0, M_SEQ, 1'b0, 32'h0, 32'h0);
    check("lit_reset_pc", PC, 32'h100);
    check("lit_reset_temp", PC_temp, 32'h100);
    check("lit_reset_cnt", 32'(RAS_count), 32'd0);

    // Sequential advance
    for (int i = 1; i <= 3; i++) begin
      go(M_SEQ, 32'h0, 32'h0);
      check("lit_seq_pc", PC, 32'h100 + 32'(4 * i));
      check("lit_seq_temp", PC_temp, 32'h100 + 32'(4 * (i - 1)));
    end

    // Branches and stall
    go(M_JREG, 32'h0, 32'h200);
    check("lit_jreg", PC, 32'h200);
    step(1'b0, 1'b1, M_BR, 1'b1, 32'hFFFF_FFF0, 32'h0);
    check("lit_br_taken", PC, 32'h1F0);
    step(1'b0, 1'b1, M_BR, 1'b0, 32'hFFFF_FFF0, 32'h0);
    check("lit_br_not", PC, 32'h1F4);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, M_CALL, 1'b1, 32'h40, 32'h0);
      check("lit_stall_pc", PC, 32'h1F4);
      check("lit_stall_temp", PC_temp, 32'h1F0);
      check("lit_stall_cnt", 32'(RAS_count), 32'd0);
    end

    // Call / return
    go(M_JREG, 32'h0, 32'h40);
    go(M_CALL, 32'h100, 32'h0);
    check("lit_call_pc", PC, 32'h140);
    check("lit_call_cnt", 32'(RAS_count), 32'd1);
    go(M_CALLR, 32'h0, 32'h800);
    check("lit_callr_pc", PC, 32'h800);
    check("lit_callr_cnt", 32'(RAS_count), 32'd2);
    go(M_RET, 32'h0, 32'h0);
    check("lit_ret1", PC, 32'h144);
    go(M_RET, 32'h0, 32'h0);
    check("lit_ret2", PC, 32'h44);
    check("lit_ret2_cnt", 32'(RAS_count), 32'd0);

    // Overflow then full unwind and underflow
    go(M_JREG, 32'h0, 32'h1000);
    for (int i = 0; i < 9; i++) begin
      go(M_CALL, 32'h10, 32'h0);
      check("lit_ovf_flag", 32'(RAS_ovf), (i == 8) ? 32'd1 : 32'd0);
    end
    check("lit_ovf_cnt", 32'(RAS_count), 32'd8);
    for (int i = 8; i >= 1; i--) begin
      go(M_RET, 32'h0, 32'h0);
      exp_pc = 32'h1000 + 32'(16 * i) + 32'd4;
      check("lit_unwind", PC, exp_pc);
    end
    go(M_RET, 32'h0, 32'hABC);
    check("lit_unf_pc", PC, 32'hABC);
    check("lit_unf_flag", 32'(RAS_unf), 32'd1);
    go(M_SEQ, 32'h0, 32'h0);
    check("lit_unf_clear", 32'(RAS_unf), 32'd0);

    // Reserved mode
    go(M_JREG, 32'h0, 32'h10);
    go(3'b110, 32'h0, 32'h0);
    check("lit_ill_pc", PC, 32'h14);
    check("lit_ill_flag", 32'(Illegal), 32'd1);
    check("lit_ill_cnt", 32'(RAS_count), 32'd0);
    go(M_SEQ, 32'h0, 32'h0);
    check("lit_ill_clear", 32'(Illegal), 32'd0);

    // Wrap-around
    go(M_JREG, 32'h0, 32'hFFFF_FFFC);
    go(M_SEQ, 32'h0, 32'h0);
    check("lit_wrap", PC, 32'h0);

    // Reset during a CALL on a full stack
    for (int i = 0; i < 8; i++) go(M_CALL, 32'h20, 32'h0);
    step(1'b1, 1'b1, M_CALL, 1'b0, 32'h20, 32'h0);
    check("lit_rst_pc", PC, 32'h100);
    check("lit_rst_cnt", 32'(RAS_count), 32'd0);
    check("lit_rst_ovf", 32'(RAS_ovf), 32'd0);

    // Randomized phase, biased toward call/return traffic
    for (int n = 0; n < 3000; n++) begin
      logic [2:0] md;
      logic [31:0] off;
      int r;
      r = $urandom_range(0, 15);
      if (r < 5) md = M_CALL;
      else if (r < 7) md = M_CALLR;
      else if (r < 12) md = M_RET;
      else md = 3'($urandom_range(0, 7));
      off = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 1023)) << 2
                                        : -(32'($urandom_range(0, 1023)) << 2);
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 7) != 0), md,
           1'($urandom_range(0, 1)), off, $urandom);
    end

    started = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
